// File: rtl/mem_seq_ctrl_if.sv
// Memory-stage bus: instruction/handshake inputs from the pipeline and memory,
// strobes and sequencing outputs from the controller.
interface mem_seq_ctrl_if #(
  parameter int IR_W  = 8,
  parameter int CNT_W = 1
);
  logic [IR_W-1:0]  ir;
  logic             valid;
  logic             intr;
  logic             mem_ready;
  logic             wm;
  logic             rm;
  logic             sm2;
  logic [CNT_W-1:0] ctx_sel;
  logic             sp_dec;
  logic             sp_inc;
  logic             stall;
  logic             int_ack;

  // Handshake: an access completes in any cycle where (wm | rm) && mem_ready;
  // the strobe and ir stay stable until then, and stall is held meanwhile.
  modport master (
    input  ir, valid, intr, mem_ready,
    output wm, rm, sm2, ctx_sel, sp_dec, sp_inc, stall, int_ack
  );

  modport slave (
    output ir, valid, intr, mem_ready,
    input  wm, rm, sm2, ctx_sel, sp_dec, sp_inc, stall, int_ack
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Memory-stage sequencer: decodes the MEM-stage instruction into memory strobes,
// handles variable-latency memory with stalls, and sequences interrupt save / RTI restore.
module mem_seq_ctrl #(
  parameter int IR_W      = 8,
  parameter int CTX_WORDS = 2,
  parameter int CNT_W     = (CTX_WORDS > 1) ? $clog2(CTX_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_seq_ctrl_if.master    bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_INT_SAVE = 2'd2,
    S_RTI_LOAD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CTX_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [3:0] w_op;
  logic [1:0] w_ra;
  logic       w_is_wr, w_is_rd, w_op_dec, w_op_inc, w_is_rti;

  logic             w_wm, w_rm, w_sm2, w_sp_dec, w_sp_inc, w_stall, w_int_ack;
  logic [CNT_W-1:0] w_ctx_sel;

  assign w_op = bus.ir[IR_W-1 -: 4];
  assign w_ra = bus.ir[IR_W-5 -: 2];

  always_comb begin
    w_is_wr  = 1'b0;
    w_is_rd  = 1'b0;
    w_op_dec = 1'b0;
    w_op_inc = 1'b0;
    w_is_rti = 1'b0;
    case (w_op)
      4'd7: begin
        w_is_wr  = (w_ra == 2'd0);
        w_op_dec = (w_ra == 2'd0);
        w_is_rd  = (w_ra == 2'd1);
        w_op_inc = (w_ra == 2'd1);
      end
      4'd11: begin
        w_is_wr  = (w_ra == 2'd1);
        w_op_dec = (w_ra == 2'd1);
        w_is_rd  = (w_ra == 2'd2);
        w_op_inc = (w_ra == 2'd2);
        w_is_rti = (w_ra == 2'd3);
      end
      4'd12: begin
        w_is_wr = (w_ra == 2'd2);
        w_is_rd = (w_ra == 2'd1);
      end
      4'd13:   w_is_rd = 1'b1;
      4'd14:   w_is_wr = 1'b1;
      default: ;
    endcase
  end

  // Outputs are forced low while rst is high so an aborted sequence emits no pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wm        = 1'b0;
    w_rm        = 1'b0;
    w_sm2       = 1'b0;
    w_ctx_sel   = '0;
    w_sp_dec    = 1'b0;
    w_sp_inc    = 1'b0;
    w_stall     = 1'b0;
    w_int_ack   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (bus.intr) begin
            w_stall     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_INT_SAVE;
          end else if (bus.valid && w_is_rti) begin
            w_stall     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RTI_LOAD;
          end else if (bus.valid && (w_is_wr || w_is_rd)) begin
            w_wm  = w_is_wr;
            w_rm  = w_is_rd;
            w_sm2 = w_is_rd;
            if (bus.mem_ready) begin
              w_sp_dec = w_op_dec;
              w_sp_inc = w_op_inc;
            end else begin
              w_stall     = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          w_wm  = w_is_wr;
          w_rm  = w_is_rd;
          w_sm2 = w_is_rd;
          if (bus.mem_ready) begin
            w_sp_dec    = w_op_dec;
            w_sp_inc    = w_op_inc;
            w_state_nxt = S_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
        S_INT_SAVE: begin
          w_wm      = 1'b1;
          w_ctx_sel = r_cnt;
          w_stall   = 1'b1;
          if (bus.mem_ready) begin
            w_sp_dec = 1'b1;
            if (r_cnt == LAST_WORD) begin
              w_int_ack   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        S_RTI_LOAD: begin
          w_rm      = 1'b1;
          w_sm2     = 1'b1;
          w_ctx_sel = r_cnt;
          w_stall   = 1'b1;
          if (bus.mem_ready) begin
            w_sp_inc = 1'b1;
            if (r_cnt == LAST_WORD) begin
              w_stall     = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.wm       = w_wm;
  assign bus.rm       = w_rm;
  assign bus.sm2      = w_sm2;
  assign bus.ctx_sel  = w_ctx_sel;
  assign bus.sp_dec   = w_sp_dec;
  assign bus.sp_inc   = w_sp_inc;
  assign bus.stall    = w_stall;
  assign bus.int_ack  = w_int_ack;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed-vector bench for mem_seq_ctrl: one instance with 2 context words, one with 3.
module tb_mem_seq_ctrl;

  typedef struct {
    string      name;
    logic [7:0] ir;
    logic       valid;
    logic       intr;
    logic       rdy;
    logic       rst;
    logic [8:0] exp;  // {wm, rm, sm2, ctx_sel[1:0], sp_dec, sp_inc, stall, int_ack}
  } vec_t;

  logic clk;
  logic tb_rst;
  logic [7:0] tb_ir;
  logic tb_valid, tb_intr, tb_rdy;
  logic [1:0] dbg2, dbg3;
  logic [8:0] act2, act3;

  int n_applied = 0;
  int n_fail    = 0;
  logic [8:0] exp_q[$];
  vec_t vecs[$];
  vec_t vecs3[$];

  mem_seq_ctrl_if #(.IR_W(8), .CNT_W(1)) bus2 ();
  mem_seq_ctrl_if #(.IR_W(8), .CNT_W(2)) bus3 ();

  mem_seq_ctrl #(.IR_W(8), .CTX_WORDS(2)) dut2 (
    .clk(clk), .rst(tb_rst), .bus(bus2.master), .o_dbg_state(dbg2)
  );
  mem_seq_ctrl #(.IR_W(8), .CTX_WORDS(3)) dut3 (
    .clk(clk), .rst(tb_rst), .bus(bus3.master), .o_dbg_state(dbg3)
  );

  assign bus2.ir = tb_ir;  assign bus2.valid = tb_valid;
  assign bus2.intr = tb_intr;  assign bus2.mem_ready = tb_rdy;
  assign bus3.ir = tb_ir;  assign bus3.valid = tb_valid;
  assign bus3.intr = tb_intr;  assign bus3.mem_ready = tb_rdy;

  assign act2 = {bus2.wm, bus2.rm, bus2.sm2, 1'b0, bus2.ctx_sel, bus2.sp_dec,
                 bus2.sp_inc, bus2.stall, bus2.int_ack};
  assign act3 = {bus3.wm, bus3.rm, bus3.sm2, bus3.ctx_sel, bus3.sp_dec,
                 bus3.sp_inc, bus3.stall, bus3.int_ack};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic [7:0] ir, input logic valid,
                              input logic intr, input logic rdy, input logic rst,
                              input logic [8:0] exp);
    vec_t v;
    v.name = nm; v.ir = ir; v.valid = valid; v.intr = intr;
    v.rdy = rdy; v.rst = rst; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (wm rm sm2 ctx dec inc stall ack)", nm, act, exp);
    end
  endtask

  // Driver: inputs change just after the falling edge, outputs sampled 1 ns later.
  task automatic apply(input vec_t v, input bit use3);
    logic [8:0] e;
    @(negedge clk);
    tb_ir = v.ir; tb_valid = v.valid; tb_intr = v.intr;
    tb_rdy = v.rdy; tb_rst = v.rst;
    #1;
    exp_q.push_back(v.exp);
    e = exp_q.pop_front();
    check(v.name, use3 ? act3 : act2, e);
  endtask

  initial begin
    tb_rst = 1'b1; tb_ir = 8'h00; tb_valid = 1'b0; tb_intr = 1'b0; tb_rdy = 1'b1;

    // CTX_WORDS = 2 sequence (state carries from one vector to the next)
    vecs.push_back(mk("reset_cycle",     8'h00, 0, 0, 1, 1, 9'b000_00_0000));
    vecs.push_back(mk("after_reset",     8'h00, 0, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("bubble_push",     8'h70, 0, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("push_wait",       8'h70, 1, 0, 0, 0, 9'b100_00_0010));
    vecs.push_back(mk("push_done",       8'h70, 1, 0, 1, 0, 9'b100_00_1000));
    vecs.push_back(mk("ldd_retire",      8'hC4, 1, 0, 1, 0, 9'b011_00_0000));
    vecs.push_back(mk("call",            8'hB4, 1, 0, 1, 0, 9'b100_00_1000));
    vecs.push_back(mk("ret",             8'hB8, 1, 0, 1, 0, 9'b011_00_0100));
    vecs.push_back(mk("std",             8'hC8, 1, 0, 1, 0, 9'b100_00_0000));
    vecs.push_back(mk("sti",             8'hE3, 1, 0, 1, 0, 9'b100_00_0000));
    vecs.push_back(mk("ldi",             8'hD9, 1, 0, 1, 0, 9'b011_00_0000));
    vecs.push_back(mk("alu_op",          8'h10, 1, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("op7_ra3",         8'h7C, 1, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("op12_ra0",        8'hC0, 1, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("rti_entry",       8'hBC, 1, 0, 1, 0, 9'b000_00_0010));
    vecs.push_back(mk("rti_w0_wait",     8'hBC, 1, 0, 0, 0, 9'b011_00_0010));
    vecs.push_back(mk("rti_w0_done",     8'hBC, 1, 0, 1, 0, 9'b011_00_0110));
    vecs.push_back(mk("rti_w1_wait",     8'hBC, 1, 0, 0, 0, 9'b011_01_0010));
    vecs.push_back(mk("rti_w1_retire",   8'hBC, 1, 0, 1, 0, 9'b011_01_0100));
    vecs.push_back(mk("rti_back_idle",   8'hBC, 0, 0, 1, 0, 9'b000_00_0000));
    vecs.push_back(mk("pop_wait",        8'h74, 1, 0, 0, 0, 9'b011_00_0010));
    vecs.push_back(mk("pop_wait_intr",   8'h74, 1, 1, 0, 0, 9'b011_00_0010));
    vecs.push_back(mk("pop_done_intr",   8'h74, 1, 1, 1, 0, 9'b011_00_0100));
    vecs.push_back(mk("intr_entry",      8'h74, 1, 1, 1, 0, 9'b000_00_0010));
    vecs.push_back(mk("save_w0",         8'h74, 1, 1, 1, 0, 9'b100_00_1010));
    vecs.push_back(mk("save_w1_ack",     8'h74, 1, 1, 1, 0, 9'b100_01_1011));
    vecs.push_back(mk("pop_replayed",    8'h74, 1, 0, 1, 0, 9'b011_00_0100));
    vecs.push_back(mk("intr_no_valid",   8'h00, 0, 1, 1, 0, 9'b000_00_0010));
    vecs.push_back(mk("rst_mid_save",    8'h00, 0, 1, 1, 1, 9'b000_00_0000));
    vecs.push_back(mk("after_abort",     8'h00, 0, 0, 1, 0, 9'b000_00_0000));

    // CTX_WORDS = 3 interrupt save, with one memory wait on the second word
    vecs3.push_back(mk("c3_reset",       8'h00, 0, 0, 1, 1, 9'b000_00_0000));
    vecs3.push_back(mk("c3_entry",       8'h00, 0, 1, 1, 0, 9'b000_00_0010));
    vecs3.push_back(mk("c3_w0",          8'h00, 0, 1, 1, 0, 9'b100_00_1010));
    vecs3.push_back(mk("c3_w1_wait",     8'h00, 0, 1, 0, 0, 9'b100_01_0010));
    vecs3.push_back(mk("c3_w1",          8'h00, 0, 1, 1, 0, 9'b100_01_1010));
    vecs3.push_back(mk("c3_w2_ack",      8'h00, 0, 1, 1, 0, 9'b100_10_1011));
    vecs3.push_back(mk("c3_idle",        8'h00, 0, 0, 1, 0, 9'b000_00_0000));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("dbg_state_reset", {7'd0, dbg2}, 9'd0);

    foreach (vecs[i]) apply(vecs[i], 1'b0);
    foreach (vecs3[i]) apply(vecs3[i], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
